// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: 16-entry 2-bit branch predictor with EX-stage redirect/flush control
module branch_predict_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [2:0]  ex_branch,
    input  logic        ex_zero,
    input  logic        ex_pred_taken,
    input  logic        stall,
    output logic [1:0]  pc_src,
    output logic        jump_reg,
    output logic        flush,
    output logic [15:0] branch_cnt,
    output logic [15:0] mispred_cnt
);
    localparam logic [1:0] S_NORMAL  = 2'd0;
    localparam logic [1:0] S_RECOVER = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  r_sel;
    logic        r_jr;
    logic [1:0]  r_ctr [16];
    logic [15:0] r_bc;
    logic [15:0] r_mc;
    logic        w_resolve;
    logic        w_cond;
    logic        w_jump;
    logic        w_actual;
    logic        w_redirect;
    logic [1:0]  w_sel;
    logic [1:0]  w_cur;
    logic [1:0]  w_next;
    logic        w_unused;

    assign w_unused   = &{1'b0, if_pc[31:6], if_pc[1:0], ex_pc[31:6], ex_pc[1:0]};
    assign w_resolve  = ex_valid & ~stall & (r_state == S_NORMAL);
    assign w_cond     = (ex_branch == 3'b001) | (ex_branch == 3'b100);
    assign w_jump     = (ex_branch == 3'b010) | (ex_branch == 3'b011);
    assign w_actual   = (ex_branch == 3'b001) ? ex_zero : ~ex_zero;
    assign w_redirect = w_resolve & ((w_cond & (w_actual != ex_pred_taken)) | w_jump);
    assign w_sel      = w_jump ? 2'b11 : (w_actual ? 2'b01 : 2'b10);
    assign w_cur      = r_ctr[ex_pc[5:2]];
    assign w_next     = w_actual ? ((w_cur == 2'b11) ? 2'b11 : w_cur + 2'b01)
                                 : ((w_cur == 2'b00) ? 2'b00 : w_cur - 2'b01);

    assign pred_taken  = if_valid & r_ctr[if_pc[5:2]][1];
    assign pc_src      = (r_state == S_RECOVER) ? r_sel : 2'b00;
    assign jump_reg    = (r_state == S_RECOVER) & r_jr;
    assign flush       = (r_state == S_RECOVER) | (r_state == S_DRAIN);
    assign branch_cnt  = r_bc;
    assign mispred_cnt = r_mc;

    // Recovery sequence: one redirect cycle, then one squash-only cycle; stall freezes it
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_NORMAL;
        else if (!stall)
            r_state <= (r_state == S_NORMAL) ? (w_redirect ? S_RECOVER : S_NORMAL) :
                       (r_state == S_RECOVER) ? S_DRAIN : S_NORMAL;
    end

    // Capture the redirect target select at resolve time for use in RECOVER
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel <= 2'b00;
            r_jr  <= 1'b0;
        end else if (w_redirect) begin
            r_sel <= w_sel;
            r_jr  <= (ex_branch == 3'b011);
        end
    end

    // Train the saturating counter of a resolved conditional branch
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) r_ctr[i] <= 2'b01;
        end else if (w_resolve && w_cond) begin
            r_ctr[ex_pc[5:2]] <= w_next;
        end
    end

    // Saturating statistics counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bc <= 16'd0;
            r_mc <= 16'd0;
        end else begin
            if (w_resolve && w_cond) r_bc <= r_bc + 16'(r_bc != 16'hFFFF);
            if (w_redirect)          r_mc <= r_mc + 16'(r_mc != 16'hFFFF);
        end
    end
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// tb_branch_predict_ctrl: directed vector table plus randomized run against a behavioural model
module tb_branch_predict_ctrl;
    logic        clk = 1'b0;
    logic        rst, if_valid, ex_valid, ex_zero, ex_pred_taken, stall;
    logic [31:0] if_pc, ex_pc;
    logic [2:0]  ex_branch;
    logic        pred_taken, jump_reg, flush;
    logic [1:0]  pc_src;
    logic [15:0] branch_cnt, mispred_cnt;

    int n_vec = 0;
    int n_bad = 0;

    branch_predict_ctrl dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .pred_taken(pred_taken),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_branch(ex_branch), .ex_zero(ex_zero),
        .ex_pred_taken(ex_pred_taken), .stall(stall), .pc_src(pc_src), .jump_reg(jump_reg),
        .flush(flush), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, iv;
        logic [31:0] ipc;
        logic        ev;
        logic [31:0] epc;
        logic [2:0]  br;
        logic        z, ep, st;
        logic [1:0]  pc;
        logic        fl, jr, pt;
        logic [15:0] bc, mc;
    } vec_t;

    vec_t tab[$];

    // Behavioural model: counters as integers 0..3, recovery as "flush cycles left"
    int m_ctr[16];
    int m_bc, m_mc, m_left, m_sel;
    bit m_jr;

    function automatic vec_t v(input logic r, iv, input logic [31:0] ipc, input logic ev,
                               input logic [31:0] epc, input logic [2:0] br, input logic z, ep, st,
                               input logic [1:0] pc, input logic fl, jr, pt, input logic [15:0] bc, mc);
        vec_t t;
        t.rst = r; t.iv = iv; t.ipc = ipc; t.ev = ev; t.epc = epc; t.br = br; t.z = z; t.ep = ep;
        t.st = st; t.pc = pc; t.fl = fl; t.jr = jr; t.pt = pt; t.bc = bc; t.mc = mc;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        rst = t.rst; if_valid = t.iv; if_pc = t.ipc; ex_valid = t.ev; ex_pc = t.epc;
        ex_branch = t.br; ex_zero = t.z; ex_pred_taken = t.ep; stall = t.st;
    endtask

    task automatic model_update();
        int idx;
        bit cond, taken, jmp;
        if (rst) begin
            for (int i = 0; i < 16; i++) m_ctr[i] = 1;
            m_bc = 0; m_mc = 0; m_left = 0; m_sel = 0; m_jr = 0;
        end else if (!stall) begin
            if (m_left > 0) m_left--;
            else if (ex_valid) begin
                idx   = int'(ex_pc[5:2]);
                cond  = (ex_branch == 1) || (ex_branch == 4);
                jmp   = (ex_branch == 2) || (ex_branch == 3);
                taken = (ex_branch == 1) ? ex_zero : !ex_zero;
                if (cond) begin
                    m_ctr[idx] = taken ? ((m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3)
                                       : ((m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0);
                    if (m_bc < 65535) m_bc++;
                end
                if ((cond && (taken != ex_pred_taken)) || jmp) begin
                    if (m_mc < 65535) m_mc++;
                    m_left = 2;
                    m_sel  = jmp ? 3 : (taken ? 1 : 2);
                    m_jr   = (ex_branch == 3);
                end
            end
        end
    endtask

    task automatic clock_edge();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic check_model();
        chk("pred_taken", pred_taken, if_valid && (m_ctr[int'(if_pc[5:2])] >= 2));
        chk("pc_src", pc_src, (m_left == 2) ? m_sel : 0);
        chk("jump_reg", jump_reg, (m_left == 2) && m_jr);
        chk("flush", flush, m_left > 0);
        chk("branch_cnt", branch_cnt, m_bc);
        chk("mispred_cnt", mispred_cnt, m_mc);
    endtask

    initial begin
        // rst iv ipc  ev epc br z ep st | pc fl jr pt bc mc
        tab.push_back(v(0,1,'h40, 0,0,    0,0,0,0, 0,0,0,0,0,0));
        tab.push_back(v(0,1,'h40, 1,'h40, 1,1,0,0, 0,0,0,0,0,0));
        tab.push_back(v(0,1,'h40, 0,0,    0,0,0,0, 1,1,0,1,1,1));
        tab.push_back(v(0,1,'h40, 0,0,    0,0,0,0, 0,1,0,1,1,1));
        tab.push_back(v(0,1,'h44, 1,'h44, 4,1,1,0, 0,0,0,0,1,1));
        tab.push_back(v(0,1,'h44, 0,0,    0,0,0,0, 2,1,0,0,2,2));
        tab.push_back(v(0,1,'h44, 0,0,    0,0,0,0, 0,1,0,0,2,2));
        tab.push_back(v(0,1,'h44, 1,'h44, 4,1,0,0, 0,0,0,0,2,2));
        tab.push_back(v(0,1,'h44, 1,'h48, 3,0,0,0, 0,0,0,0,3,2));
        tab.push_back(v(0,1,'h48, 1,'h48, 1,1,0,0, 3,1,1,0,3,3));
        tab.push_back(v(0,1,'h48, 1,'h48, 1,1,0,0, 0,1,0,0,3,3));
        tab.push_back(v(0,1,'h48, 1,'h4C, 1,1,0,0, 0,0,0,0,3,3));
        tab.push_back(v(0,1,'h4C, 1,'h4C, 1,1,0,1, 1,1,0,1,4,4));
        tab.push_back(v(0,1,'h4C, 1,'h4C, 1,1,0,1, 1,1,0,1,4,4));
        tab.push_back(v(0,1,'h4C, 1,'h4C, 1,1,0,1, 1,1,0,1,4,4));
        tab.push_back(v(0,1,'h4C, 0,0,    0,0,0,0, 1,1,0,1,4,4));
        tab.push_back(v(0,1,'h4C, 0,0,    0,0,0,0, 0,1,0,1,4,4));
        tab.push_back(v(0,1,'h4C, 1,'h4C, 1,0,1,0, 0,0,0,1,4,4));
        tab.push_back(v(1,1,'h4C, 0,0,    0,0,0,0, 2,1,0,0,5,5));
        tab.push_back(v(0,1,'h40, 1,'h50, 1,1,1,0, 0,0,0,0,0,0));
        tab.push_back(v(0,1,'h50, 1,'h50, 1,1,1,0, 0,0,0,1,1,0));
        tab.push_back(v(0,1,'h50, 1,'h50, 1,1,1,0, 0,0,0,1,2,0));
        tab.push_back(v(0,1,'h50, 1,'h50, 1,1,1,0, 0,0,0,1,3,0));
        tab.push_back(v(0,1,'h50, 1,'h50, 1,0,1,1, 0,0,0,1,4,0));
        tab.push_back(v(0,1,'h50, 1,'h50, 4,0,1,0, 0,0,0,1,4,0));
        tab.push_back(v(0,0,'h50, 0,0,    0,0,0,0, 0,0,0,0,5,0));
        tab.push_back(v(0,1,'h50, 1,'h50, 1,0,1,0, 0,0,0,1,5,0));
        tab.push_back(v(0,1,'h50, 0,0,    0,0,0,0, 2,1,0,1,6,1));
        tab.push_back(v(0,1,'h50, 0,0,    0,0,0,0, 0,1,0,1,6,1));
        tab.push_back(v(0,1,'h50, 1,'h50, 7,0,1,0, 0,0,0,1,6,1));
        tab.push_back(v(0,1,'h50, 1,'h54, 2,0,0,0, 0,0,0,1,6,1));
        tab.push_back(v(0,1,'h50, 0,0,    0,0,0,0, 3,1,0,1,6,2));
        tab.push_back(v(0,1,'h50, 0,0,    0,0,0,0, 0,1,0,1,6,2));
        tab.push_back(v(0,1,'h50, 0,0,    0,0,0,0, 0,0,0,1,6,2));

        drive(v(1,0,0, 0,0,0,0,0,1, 0,0,0,0,0,0));
        clock_edge();
        clock_edge();
        rst = 1'b0; stall = 1'b0; if_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if_pc = 32'(i * 4);
            @(negedge clk);
            chk("reset_pred", pred_taken, 1'b0);
            if (i == 0) begin
                chk("reset_pc_src", pc_src, 2'b00);
                chk("reset_flush", flush, 1'b0);
                chk("reset_bc", branch_cnt, 16'd0);
                chk("reset_mc", mispred_cnt, 16'd0);
            end
            clock_edge();
        end

        for (int r = 0; r < tab.size(); r++) begin
            drive(tab[r]);
            @(negedge clk);
            chk($sformatf("row%0d_pc_src", r), pc_src, tab[r].pc);
            chk($sformatf("row%0d_flush", r), flush, tab[r].fl);
            chk($sformatf("row%0d_jump_reg", r), jump_reg, tab[r].jr);
            chk($sformatf("row%0d_pred", r), pred_taken, tab[r].pt);
            chk($sformatf("row%0d_bc", r), branch_cnt, tab[r].bc);
            chk($sformatf("row%0d_mc", r), mispred_cnt, tab[r].mc);
            clock_edge();
        end

        rst = 1'b1;
        clock_edge();
        for (int c = 0; c < 3000; c++) begin
            rst           = ($urandom_range(0, 99) == 0);
            stall         = ($urandom_range(0, 4) == 0);
            if_valid      = $urandom_range(0, 1);
            if_pc         = $urandom;
            ex_valid      = ($urandom_range(0, 2) != 0);
            ex_pc         = $urandom;
            ex_branch     = 3'($urandom_range(0, 7));
            ex_zero       = $urandom_range(0, 1);
            ex_pred_taken = $urandom_range(0, 1);
            @(negedge clk);
            check_model();
            clock_edge();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/branch_predict_ctrl.md
BRANCH_PREDICT_CTRL -- requirements
Module: branch_predict_ctrl

Interface
REQ-001 SHALL: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL: if_valid  in  1  fetch-stage lookup request.
REQ-004 SHALL: if_pc  in  32  fetch PC; predictor index = if_pc[5:2].
REQ-005 SHALL: pred_taken  out  1  prediction for if_pc, carried down the pipe by the datapath.
REQ-006 SHALL: ex_valid  in  1  EX stage holds a valid instruction.
REQ-007 SHALL: ex_pc  in  32  PC of the EX instruction; update index = ex_pc[5:2].
REQ-008 SHALL: ex_branch  in  3  branch type: 000 none, 001 beq, 010 j/jal, 011 jr, 100 bne; 101-111 treated as none.
REQ-009 SHALL: ex_zero  in  1  ALU zero flag of the EX instruction.
REQ-010 SHALL: ex_pred_taken  in  1  pred_taken value issued when the EX instruction was fetched.
REQ-011 SHALL: stall  in  1  global pipeline stall.
REQ-012 SHALL: pc_src  out  2  00 fetch normally (PC+4 or predicted target), 01 branch target, 10 ex_pc+4 fallthrough, 11 jump target.
REQ-013 SHALL: jump_reg  out  1  with pc_src=11: 1 selects register target (jr), 0 selects immediate target (j/jal).
REQ-014 SHALL: flush  out  1  squash IF/ID and ID/EX contents.
REQ-015 SHALL: branch_cnt, mispred_cnt  out  16 each  resolved conditional branches / redirects taken.

Function
REQ-016 SHALL: predictor = 16 x 2-bit saturating counters; pred_taken = counter[if_pc[5:2]][1] when if_valid, else 0 (combinational read).
REQ-017 SHALL: actual_taken = ex_zero for beq, !ex_zero for bne.
REQ-018 SHALL: "resolve" = ex_valid & !stall & state==NORMAL; EX inputs outside resolve are ignored entirely.
REQ-019 SHALL: on resolve of beq/bne, counter[ex_pc[5:2]] increments (sat at 11) if actual_taken, else decrements (sat at 00).
REQ-020 SHALL: same-cycle lookup and update of one index returns the pre-update value.
REQ-021 SHALL: on resolve of beq/bne, branch_cnt increments, saturating at 16'hFFFF.
REQ-022 SHALL: redirect condition = resolve & (conditional & actual_taken != ex_pred_taken, or ex_branch 010/011).
REQ-023 SHALL: on redirect condition, latch target select (01 if taken mispredict, 10 if not-taken mispredict, 11 for jumps; jump_reg=1 only for 011), increment mispred_cnt (sat FFFF), enter RECOVER next cycle.
REQ-024 SHALL: FSM states NORMAL, RECOVER, DRAIN; NORMAL->RECOVER on redirect, RECOVER->DRAIN, DRAIN->NORMAL, each advance only when stall=0.
REQ-025 SHALL: NORMAL: pc_src=00, flush=0, jump_reg=0.
REQ-026 SHALL: RECOVER: pc_src=latched select, jump_reg=latched, flush=1 (exactly one unstalled cycle of redirect).
REQ-027 SHALL: DRAIN: pc_src=00, flush=1, jump_reg=0; squashes the second wrong-path instruction.
REQ-028 SHALL: stall=1 holds state, outputs, counters and predictor unchanged.
REQ-029 SHALL: correct predictions cause no redirect, no flush, zero penalty.

Reset
REQ-030 SHALL: rst=1 at a clock edge forces state NORMAL, all predictor entries 01, branch_cnt=mispred_cnt=0, latched select 00, jump_reg 0; outputs pc_src=00, flush=0 in the following cycle.
REQ-031 SHALL: rst overrides stall and any in-progress RECOVER/DRAIN; no redirect is issued after reset.

Verification
REQ-032 SHALL: after reset, if_pc=0x40, if_valid=1 -> pred_taken=0; all 16 entries read 01.
REQ-033 SHALL: beq at ex_pc=0x40, ex_zero=1, ex_pred_taken=0 -> next cycle pc_src=01, flush=1; then pc_src=00, flush=1; then flush=0; entry 0 = 10, pred_taken for 0x40 = 1; branch_cnt=1, mispred_cnt=1.
REQ-034 SHALL: bne at 0x44, ex_zero=1, ex_pred_taken=1 -> pc_src=10 for one cycle, flush for two; entry 1 stays 00 after second not-taken.
REQ-035 SHALL: jr (011) resolved -> pc_src=11, jump_reg=1, flush=1; mispred_cnt+1, branch_cnt unchanged, no predictor change.
REQ-036 SHALL: stall=1 held 3 cycles during RECOVER -> pc_src=01, flush=1 held 3 cycles; DRAIN follows first unstalled cycle; EX branch presented during RECOVER/DRAIN -> no counter or predictor change.
REQ-037 SHALL: rst asserted in RECOVER -> next cycle pc_src=00, flush=0, counters 0; 4 taken beq at one index saturate entry at 11.
